// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | cpu_pkg: shared constants and types for the MIPS core pipeline |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
package cpu_pkg;

  localparam int NREG_DEF = 32;
  localparam int CW_DEF   = 2;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_ES   = 2'd1,
    FWD_MS   = 2'd2,
    FWD_WS   = 2'd3
  } fwd_src_e;

endpackage
`default_nettype wire

// File: rtl/sb_cnt_bank.sv
`default_nettype none
// +----------------------------------------------------------------+
// | sb_cnt_bank: per-register in-flight writer counters + sb_err   |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module sb_cnt_bank
  import cpu_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             issue_i,
  input  logic [REG_W-1:0] issue_dest_i,
  input  logic             retire_i,
  input  logic [REG_W-1:0] retire_dest_i,
  output logic [NREG-1:0]  busy_o,
  output logic [NREG-1:0]  sat_o,
  output logic             sb_err_o
);

  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [NREG-1:0] ONE_HOT = NREG'(1);

  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic            err_q, err_d;
  logic [NREG-1:0] w_iss_hot, w_ret_hot;

  assign w_iss_hot = issue_i  ? (ONE_HOT << issue_dest_i)  : '0;
  assign w_ret_hot = retire_i ? (ONE_HOT << retire_dest_i) : '0;

  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush_i) begin
        cnt_d[r] = '0;
      end else if (r != 0) begin
        // A retire and an issue on the same register cancel out.
        if (w_iss_hot[r] && !w_ret_hot[r]) begin
          cnt_d[r] = cnt_q[r] + CW'(1);
        end else if (w_ret_hot[r] && !w_iss_hot[r] && cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CW'(1);
        end
        if (w_ret_hot[r] && cnt_q[r] == '0) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_o[r] = (cnt_q[r] != '0);
      sat_o[r]  = (cnt_q[r] == CNT_MAX);
    end
  end

  assign sb_err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------+
// | hazard_scoreboard: decode-stage stall and operand forwarding   |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ds_valid,
  input  logic [REG_W-1:0]  ds_rs,
  input  logic [REG_W-1:0]  ds_rt,
  input  logic              ds_rs_used,
  input  logic              ds_rt_used,
  input  logic              ds_gr_we,
  input  logic [REG_W-1:0]  ds_dest,
  input  logic              ds_issue,
  input  logic              es_valid,
  input  logic              es_gr_we,
  input  logic [REG_W-1:0]  es_dest,
  input  logic              es_is_load,
  input  logic [DATA_W-1:0] es_result,
  input  logic              ms_valid,
  input  logic              ms_gr_we,
  input  logic [REG_W-1:0]  ms_dest,
  input  logic [DATA_W-1:0] ms_result,
  input  logic              ws_valid,
  input  logic              ws_gr_we,
  input  logic [REG_W-1:0]  ws_dest,
  input  logic [DATA_W-1:0] ws_result,
  input  logic              flush,
  output logic              ds_stall,
  output logic              rs_fwd,
  output logic              rt_fwd,
  output logic [DATA_W-1:0] rs_fwd_data,
  output logic [DATA_W-1:0] rt_fwd_data,
  output logic              sb_err
);

  logic [NREG-1:0]  w_busy, w_sat;
  logic             w_issue, w_retire, w_sat_stall;
  logic [REG_W-1:0] w_src  [2];
  logic [1:0]       w_used;

  assign w_issue  = ds_issue && ds_gr_we && (ds_dest != REG_ZERO);
  assign w_retire = ws_valid && ws_gr_we && (ws_dest != REG_ZERO);

  sb_cnt_bank #(
    .NREG (NREG),
    .CW   (CW)
  ) u_cnt_bank (
    .clk           (clk),
    .resetn        (resetn),
    .flush_i       (flush),
    .issue_i       (w_issue),
    .issue_dest_i  (ds_dest),
    .retire_i      (w_retire),
    .retire_dest_i (ws_dest),
    .busy_o        (w_busy),
    .sat_o         (w_sat),
    .sb_err_o      (sb_err)
  );

  assign w_src[0] = ds_rs;
  assign w_src[1] = ds_rt;
  assign w_used   = {ds_rt_used, ds_rs_used};

  for (genvar g = 0; g < 2; g++) begin : g_src
    fwd_src_e          sel;
    logic              need_stall;
    logic              fwd;
    logic [DATA_W-1:0] data;

    // Youngest producer wins; a pending writer with no visible producer must stall.
    always_comb begin
      sel        = FWD_NONE;
      need_stall = 1'b0;
      if (w_used[g] && w_src[g] != REG_ZERO) begin
        if (es_valid && es_gr_we && es_dest == w_src[g]) begin
          sel        = FWD_ES;
          need_stall = es_is_load;
        end else if (ms_valid && ms_gr_we && ms_dest == w_src[g]) begin
          sel = FWD_MS;
        end else if (ws_valid && ws_gr_we && ws_dest == w_src[g]) begin
          sel = FWD_WS;
        end else begin
          need_stall = w_busy[w_src[g]];
        end
      end
    end

    always_comb begin
      data = '0;
      if (ds_valid) begin
        case (sel)
          FWD_ES:  data = es_result;
          FWD_MS:  data = ms_result;
          FWD_WS:  data = ws_result;
          default: data = '0;
        endcase
      end
    end

    assign fwd = ds_valid && (sel != FWD_NONE);
  end

  assign w_sat_stall = ds_gr_we && (ds_dest != REG_ZERO) && w_sat[ds_dest];

  assign ds_stall    = ds_valid && !flush &&
                       (g_src[0].need_stall || g_src[1].need_stall || w_sat_stall);
  assign rs_fwd      = g_src[0].fwd;
  assign rt_fwd      = g_src[1].fwd;
  assign rs_fwd_data = g_src[0].data;
  assign rt_fwd_data = g_src[1].data;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_hazard_scoreboard: directed + random checks of the scoreboard|
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module tb_hazard_scoreboard;

  logic        clk, resetn;
  logic        ds_valid, ds_rs_used, ds_rt_used, ds_gr_we, ds_issue;
  logic [4:0]  ds_rs, ds_rt, ds_dest;
  logic        es_valid, es_gr_we, es_is_load;
  logic [4:0]  es_dest;
  logic [31:0] es_result;
  logic        ms_valid, ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ws_valid, ws_gr_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_result;
  logic        flush;
  logic        ds_stall, rs_fwd, rt_fwd, sb_err;
  logic [31:0] rs_fwd_data, rt_fwd_data;

  int checks = 0;
  int errors = 0;
  int mcnt [32];
  bit merr;

  hazard_scoreboard #(.NREG(32), .CW(2)) dut (
    .clk(clk), .resetn(resetn),
    .ds_valid(ds_valid), .ds_rs(ds_rs), .ds_rt(ds_rt),
    .ds_rs_used(ds_rs_used), .ds_rt_used(ds_rt_used),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_issue(ds_issue),
    .es_valid(es_valid), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .es_is_load(es_is_load), .es_result(es_result),
    .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .ws_valid(ws_valid), .ws_gr_we(ws_gr_we), .ws_dest(ws_dest), .ws_result(ws_result),
    .flush(flush), .ds_stall(ds_stall),
    .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
    .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data),
    .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    merr = 1'b0;
  endtask

  task automatic clr();
    ds_valid = 0; ds_rs = 0; ds_rt = 0; ds_rs_used = 0; ds_rt_used = 0;
    ds_gr_we = 0; ds_dest = 0; ds_issue = 0;
    es_valid = 0; es_gr_we = 0; es_dest = 0; es_is_load = 0; es_result = 0;
    ms_valid = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0;
    ws_valid = 0; ws_gr_we = 0; ws_dest = 0; ws_result = 0;
    flush = 0;
  endtask

  // Reference: youngest matching stage supplies the value; pending with no producer stalls.
  function automatic void src_exp(input logic [4:0] s, input logic used,
                                  output logic f, output logic [31:0] d, output logic st);
    f = 0; d = 0; st = 0;
    if (!used || s == 5'd0) return;
    if (es_valid && es_gr_we && es_dest == s) begin
      f = 1; d = es_result; st = es_is_load;
    end else if (ms_valid && ms_gr_we && ms_dest == s) begin
      f = 1; d = ms_result;
    end else if (ws_valid && ws_gr_we && ws_dest == s) begin
      f = 1; d = ws_result;
    end else begin
      st = (mcnt[s] != 0);
    end
  endfunction

  function automatic logic exp_stall();
    logic f0, f1, s0, s1;
    logic [31:0] d0, d1;
    src_exp(ds_rs, ds_rs_used, f0, d0, s0);
    src_exp(ds_rt, ds_rt_used, f1, d1, s1);
    return ds_valid && !flush &&
           (s0 || s1 || (ds_gr_we && ds_dest != 0 && mcnt[ds_dest] == 3));
  endfunction

  task automatic chk_all();
    logic f0, f1, s0, s1;
    logic [31:0] d0, d1;
    src_exp(ds_rs, ds_rs_used, f0, d0, s0);
    src_exp(ds_rt, ds_rt_used, f1, d1, s1);
    check("ds_stall", ds_stall, exp_stall());
    check("rs_fwd", rs_fwd, ds_valid & f0);
    check("rt_fwd", rt_fwd, ds_valid & f1);
    check("rs_fwd_data", rs_fwd_data, ds_valid ? d0 : 32'd0);
    check("rt_fwd_data", rt_fwd_data, ds_valid ? d1 : 32'd0);
    check("sb_err", sb_err, merr);
    check("issue_under_stall", ds_issue & ds_stall, 0);
  endtask

  task automatic model_update();
    logic iss, ret;
    if (!resetn) return;
    if (flush) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      return;
    end
    iss = ds_issue && ds_gr_we && ds_dest != 0;
    ret = ws_valid && ws_gr_we && ws_dest != 0;
    if (iss && ret && ds_dest == ws_dest) begin
      if (mcnt[ws_dest] == 0) merr = 1'b1;
    end else begin
      if (ret) begin
        if (mcnt[ws_dest] == 0) merr = 1'b1;
        else mcnt[ws_dest]--;
      end
      if (iss) mcnt[ds_dest]++;
    end
  endtask

  // Entered and left at a negedge with inputs already driven.
  task automatic step();
    #1;
    chk_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic issue_wr(input logic [4:0] d);
    clr(); ds_valid = 1; ds_gr_we = 1; ds_dest = d; ds_issue = 1;
    step();
  endtask

  task automatic retire_wr(input logic [4:0] d);
    clr(); ws_valid = 1; ws_gr_we = 1; ws_dest = d; ws_result = 32'h5a5a_0000 | 32'(d);
    step();
  endtask

  task automatic read_src(input logic [4:0] rs, input logic [4:0] rt);
    clr(); ds_valid = 1; ds_rs = rs; ds_rs_used = 1; ds_rt = rt; ds_rt_used = 1;
  endtask

  task automatic rand_inputs();
    ds_valid   = ($urandom % 4) != 0;
    ds_rs      = 5'($urandom % 8);
    ds_rt      = 5'($urandom % 8);
    ds_rs_used = 1'($urandom % 2);
    ds_rt_used = 1'($urandom % 2);
    ds_gr_we   = 1'($urandom % 2);
    ds_dest    = 5'($urandom % 8);
    es_valid   = 1'($urandom % 2);
    es_gr_we   = 1'($urandom % 2);
    es_dest    = 5'($urandom % 8);
    es_is_load = ($urandom % 3) == 0;
    es_result  = $urandom;
    ms_valid   = 1'($urandom % 2);
    ms_gr_we   = 1'($urandom % 2);
    ms_dest    = 5'($urandom % 8);
    ms_result  = $urandom;
    ws_valid   = 1'($urandom % 2);
    ws_gr_we   = 1'($urandom % 2);
    ws_dest    = 5'($urandom % 8);
    ws_result  = $urandom;
    if (ws_valid && ws_gr_we && ws_dest != 0 && mcnt[ws_dest] == 0) ws_gr_we = 0;
    flush      = ($urandom % 40) == 0;
    ds_issue   = 0;
    ds_issue   = ds_valid && !flush && !exp_stall() && 1'($urandom % 2);
  endtask

  initial begin
    resetn = 0;
    clr();
    mreset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", ds_stall, 0);
    check("rst_rs_fwd", rs_fwd, 0);
    check("rst_rt_fwd", rt_fwd, 0);
    check("rst_rs_data", rs_fwd_data, 0);
    check("rst_rt_data", rt_fwd_data, 0);
    check("rst_sb_err", sb_err, 0);
    resetn = 1;
    @(negedge clk);

    // Back-to-back dependency through ES
    issue_wr(5'd3);
    read_src(5'd3, 5'd0);
    es_valid = 1; es_gr_we = 1; es_dest = 3; es_result = 32'h1234;
    #1;
    check("bb_rs_fwd", rs_fwd, 1);
    check("bb_rs_data", rs_fwd_data, 32'h1234);
    check("bb_stall", ds_stall, 0);
    step();
    retire_wr(5'd3);

    // Load-use: one stall, then MS forwards
    issue_wr(5'd5);
    read_src(5'd5, 5'd0);
    es_valid = 1; es_gr_we = 1; es_dest = 5; es_is_load = 1; es_result = 32'hdead;
    #1;
    check("lu_stall", ds_stall, 1);
    step();
    read_src(5'd0, 5'd5);
    ms_valid = 1; ms_gr_we = 1; ms_dest = 5; ms_result = 32'hcafe;
    #1;
    check("lu_ms_stall", ds_stall, 0);
    check("lu_ms_fwd", rt_fwd, 1);
    check("lu_ms_data", rt_fwd_data, 32'hcafe);
    step();
    retire_wr(5'd5);

    // Two writers to r7: ES beats MS, counter drains one per retire
    issue_wr(5'd7);
    issue_wr(5'd7);
    read_src(5'd0, 5'd7);
    es_valid = 1; es_gr_we = 1; es_dest = 7; es_result = 32'h1;
    ms_valid = 1; ms_gr_we = 1; ms_dest = 7; ms_result = 32'h2;
    #1;
    check("multi_rt_fwd", rt_fwd, 1);
    check("multi_rt_data", rt_fwd_data, 32'h1);
    step();
    retire_wr(5'd7);
    read_src(5'd7, 5'd0);
    #1;
    check("multi_one_left_stall", ds_stall, 1);
    step();
    retire_wr(5'd7);
    read_src(5'd7, 5'd0);
    #1;
    check("multi_drained_stall", ds_stall, 0);
    check("multi_drained_fwd", rs_fwd, 0);
    step();

    // r9: issue+retire same cycle holds, then saturation
    issue_wr(5'd9);
    clr(); ds_valid = 1; ds_gr_we = 1; ds_dest = 9; ds_issue = 1;
    ws_valid = 1; ws_gr_we = 1; ws_dest = 9; ws_result = 32'h99;
    step();
    read_src(5'd9, 5'd0);
    #1;
    check("same_cycle_hold_stall", ds_stall, 1);
    step();
    issue_wr(5'd9);
    issue_wr(5'd9);
    clr(); ds_valid = 1; ds_gr_we = 1; ds_dest = 9;
    #1;
    check("sat_stall", ds_stall, 1);
    step();
    repeat (3) retire_wr(5'd9);
    read_src(5'd9, 5'd0);
    #1;
    check("sat_drained_stall", ds_stall, 0);
    step();

    // Flush clears r4=2, r6=1
    issue_wr(5'd4);
    issue_wr(5'd4);
    issue_wr(5'd6);
    read_src(5'd4, 5'd6);
    #1;
    check("pre_flush_stall", ds_stall, 1);
    step();
    read_src(5'd4, 5'd6);
    flush = 1;
    #1;
    check("flush_forces_no_stall", ds_stall, 0);
    step();
    read_src(5'd4, 5'd6);
    #1;
    check("post_flush_stall", ds_stall, 0);
    check("post_flush_fwd", rs_fwd, 0);
    step();

    // Retire on an idle register sets the sticky error
    retire_wr(5'd8);
    clr();
    #1;
    check("err_set", sb_err, 1);
    step();
    clr(); flush = 1;
    step();
    repeat (3) begin
      clr(); ds_valid = 1; ds_gr_we = 1; ds_dest = 0; ds_issue = 1;
      ws_valid = 1; ws_gr_we = 1; ws_dest = 0;
      step();
    end
    clr(); ds_valid = 1; ds_gr_we = 1; ds_dest = 0; ds_rs = 0; ds_rs_used = 1;
    #1;
    check("r0_no_stall", ds_stall, 0);
    check("err_sticky", sb_err, 1);
    step();

    // Asynchronous reset mid-cycle clears counters and the error
    issue_wr(5'd10);
    read_src(5'd10, 5'd0);
    #1;
    check("pre_rst_stall", ds_stall, 1);
    resetn = 0;
    mreset();
    #1;
    check("async_rst_stall", ds_stall, 0);
    check("async_rst_err", sb_err, 0);
    #1;
    resetn = 1;
    @(negedge clk);

    // Randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
